// File: rtl/secure_pkg.sv
// Shared definitions for the secure router and receiver: port count,
// Hamming(7,4) bit positions and the routed-word layout.
package secure_pkg;

  localparam int NUM_PORTS = 4;

  // Codeword bit indices (parity bits sit at the power-of-two positions)
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;

  typedef struct packed {
    logic [1:0] port;
    logic [3:0] data;
  } routed_word_t;

  typedef struct packed {
    logic         corr;
    routed_word_t word;
  } rx_entry_t;

  // Encoder used by the router side; kept here so both ends share one layout
  function automatic logic [6:0] hamming74_enc(input logic [3:0] data);
    logic [6:0] cw;
    cw     = '0;
    cw[D0] = data[0];
    cw[D1] = data[1];
    cw[D2] = data[2];
    cw[D3] = data[3];
    cw[P1] = data[0] ^ data[1] ^ data[3];
    cw[P2] = data[0] ^ data[2] ^ data[3];
    cw[P4] = data[1] ^ data[2] ^ data[3];
    return cw;
  endfunction

endpackage

// File: rtl/secure_receiver_if.sv
// Ingress lanes and egress handshake of the secure receiver.
interface secure_receiver_if;

  logic [6:0] d_in0;
  logic [6:0] d_in1;
  logic [6:0] d_in2;
  logic [6:0] d_in3;
  logic [3:0] v_in;
  logic [3:0] rdy_in;
  logic [5:0] d_out;
  logic       corr_out;
  logic       v_out;
  logic       rdy_out;

  modport master (
    output d_in0, d_in1, d_in2, d_in3, v_in, rdy_out,
    input  rdy_in, d_out, corr_out, v_out
  );

  modport slave (
    input  d_in0, d_in1, d_in2, d_in3, v_in, rdy_out,
    output rdy_in, d_out, corr_out, v_out
  );

endinterface

// File: rtl/hamming74_dec.sv
// Combinational Hamming(7,4) single-error-correcting decoder.
// A double-bit error is silently miscorrected; there is no detection of it.
module hamming74_dec
  import secure_pkg::*;
(
  input  logic [6:0] code,
  output logic [3:0] data,
  output logic       corr,
  output logic [2:0] syn
);

  logic [6:0] flip;
  logic [6:0] fixed;

  // Compute syndrome, flip the addressed bit and pull out the data bits
  always_comb begin
    syn[0] = code[P1] ^ code[D0] ^ code[D1] ^ code[D3];
    syn[1] = code[P2] ^ code[D0] ^ code[D2] ^ code[D3];
    syn[2] = code[P4] ^ code[D1] ^ code[D2] ^ code[D3];
    flip   = (syn != 3'd0) ? (7'd1 << (syn - 3'd1)) : 7'd0;
    fixed  = code ^ flip;
    data   = {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
    corr   = (syn != 3'd0);
  end

endmodule

// File: rtl/secure_receiver.sv
// Receive side of the secure router: round-robin arbitration over four
// codeword lanes, single-error correction, and a small output FIFO holding
// {corr, port, data} entries in grant order.
module secure_receiver
  import secure_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  secure_receiver_if.slave       bus,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  logic [1:0]    rr;
  logic [1:0]    gnt_idx;
  logic [1:0]    idx;
  logic          found;
  logic [3:0]    grant;
  logic          full;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic [6:0]    gnt_code;
  logic [3:0]    dec_data;
  logic          dec_corr;
  logic [2:0]    dec_syn;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  rx_entry_t     mem [DEPTH];
  rx_entry_t     head;

  assign full      = (fill == FULL_LVL);
  assign not_empty = (fill != '0);

  // Round-robin search for the first valid lane starting at rr
  always_comb begin
    found   = 1'b0;
    gnt_idx = rr;
    idx     = rr;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = rr + 2'(k);
      if (!found && bus.v_in[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Route the granted lane's codeword into the decoder
  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_code = bus.d_in0;
      2'd1:    gnt_code = bus.d_in1;
      2'd2:    gnt_code = bus.d_in2;
      default: gnt_code = bus.d_in3;
    endcase
  end

  hamming74_dec u_dec (
    .code (gnt_code),
    .data (dec_data),
    .corr (dec_corr),
    .syn  (dec_syn)
  );

  // Grant is held off entirely while in reset or while the FIFO is full
  assign grant      = (found && !full && rst_n) ? (4'b0001 << gnt_idx) : 4'b0000;
  assign bus.rdy_in = grant;
  assign push       = |grant;
  assign pop        = not_empty && bus.rdy_out;

  // Head is read from stored entries only and forced to zero when empty
  assign head         = mem[rd_ptr];
  assign bus.v_out    = not_empty;
  assign bus.d_out    = not_empty ? head.word : 6'd0;
  assign bus.corr_out = not_empty ? head.corr : 1'b0;

  // Store the decoded, port-tagged word at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{corr: dec_corr, word: '{port: gnt_idx, data: dec_data}};
    end
  end

  // Pointers, occupancy, arbitration pointer and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= 2'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      fill    <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= gnt_idx + 2'd1;
        if (dec_syn != 3'd0 && err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_receiver.sv
// Directed bench for secure_receiver with a scoreboard queue of expected
// FIFO entries. A second instance with CNT_W = 2 sees the same stimulus so
// counter saturation is observed alongside the main checks.
module tb_secure_receiver;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  secure_receiver_if bus ();
  secure_receiver_if bus_s ();

  assign bus_s.d_in0   = bus.d_in0;
  assign bus_s.d_in1   = bus.d_in1;
  assign bus_s.d_in2   = bus.d_in2;
  assign bus_s.d_in3   = bus.d_in3;
  assign bus_s.v_in    = bus.v_in;
  assign bus_s.rdy_out = bus.rdy_out;

  logic [7:0] err_cnt;
  logic [2:0] fill;
  logic [1:0] err_cnt_s;
  logic [2:0] fill_s;

  secure_receiver #(.DEPTH(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt),
    .fill    (fill)
  );

  secure_receiver #(.DEPTH(4), .CNT_W(2)) dut_small (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_s),
    .err_cnt (err_cnt_s),
    .fill    (fill_s)
  );

  int total = 0;
  int bad   = 0;
  int exp_err;
  int exp_err_s;

  logic [3:0] pdata [4];
  logic [6:0] pflip [4];
  logic [6:0] sb [$];

  // Bench-side encoder written straight from the parity equations
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic ro);
    bus.d_in0   = enc(pdata[0]) ^ pflip[0];
    bus.d_in1   = enc(pdata[1]) ^ pflip[1];
    bus.d_in2   = enc(pdata[2]) ^ pflip[2];
    bus.d_in3   = enc(pdata[3]) ^ pflip[3];
    bus.v_in    = v;
    bus.rdy_out = ro;
  endtask

  task automatic resetModel();
    sb.delete();
    exp_err   = 0;
    exp_err_s = 0;
  endtask

  task automatic checkReset(input string tag);
    check({tag, ".v_out"},    32'(bus.v_out),    32'd0);
    check({tag, ".d_out"},    32'(bus.d_out),    32'd0);
    check({tag, ".corr_out"}, 32'(bus.corr_out), 32'd0);
    check({tag, ".rdy_in"},   32'(bus.rdy_in),   32'd0);
    check({tag, ".fill"},     32'(fill),         32'd0);
    check({tag, ".err_cnt"},  32'(err_cnt),      32'd0);
    check({tag, ".err_s"},    32'(err_cnt_s),    32'd0);
    check({tag, ".fill_s"},   32'(fill_s),       32'd0);
  endtask

  // Check one cycle at the falling edge, then update the scoreboard for the
  // pop and push that the coming rising edge will perform
  task automatic checkOutput(input logic [3:0] exp_grant);
    @(negedge clk);
    check("rdy_in",   32'(bus.rdy_in),   32'(exp_grant));
    check("rdy_in_s", 32'(bus_s.rdy_in), 32'(exp_grant));
    check("v_out",    32'(bus.v_out),    32'(sb.size() != 0));
    check("v_out_s",  32'(bus_s.v_out),  32'(sb.size() != 0));
    check("fill",     32'(fill),         32'(sb.size()));
    check("fill_s",   32'(fill_s),       32'(sb.size()));
    check("err_cnt",  32'(err_cnt),      32'(exp_err));
    check("err_s",    32'(err_cnt_s),    32'(exp_err_s));
    if (sb.size() != 0) begin
      check("d_out",      32'(bus.d_out),      32'(sb[0][5:0]));
      check("corr_out",   32'(bus.corr_out),   32'(sb[0][6]));
      check("d_out_s",    32'(bus_s.d_out),    32'(sb[0][5:0]));
      check("corr_out_s", 32'(bus_s.corr_out), 32'(sb[0][6]));
    end
    if (bus.rdy_out && sb.size() != 0) void'(sb.pop_front());
    for (int p = 0; p < 4; p++) begin
      if (exp_grant[p]) begin
        sb.push_back({(pflip[p] != 7'd0), 2'(p), pdata[p]});
        if (pflip[p] != 7'd0) begin
          if (exp_err != 255) exp_err++;
          if (exp_err_s != 3) exp_err_s++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [3:0] v);
    applyStimulus(v, 1'b1);
    rst_n = 1'b0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      pdata[p] = 4'd0;
      pflip[p] = 7'd0;
    end
    resetModel();
    rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    #2;

    // Reset with port 2 already requesting; no grant while in reset
    doReset(4'b0100);

    // Single clean word on port 2
    pdata[2] = 4'b1011;
    applyStimulus(4'b0100, 1'b1);
    checkOutput(4'b0100);
    applyStimulus(4'b0000, 1'b1);
    checkOutput(4'b0000);
    checkOutput(4'b0000);

    // Every single-bit flip position on port 2 is corrected
    for (int p = 0; p < 7; p++) begin
      pflip[2] = 7'd1 << p;
      applyStimulus(4'b0100, 1'b1);
      checkOutput(4'b0100);
      applyStimulus(4'b0000, 1'b1);
      checkOutput(4'b0000);
    end
    pflip[2] = 7'd0;
    checkOutput(4'b0000);

    // Round-robin order with all four lanes requesting
    doReset(4'b0000);
    pdata[0] = 4'd3;
    pdata[1] = 4'd6;
    pdata[2] = 4'd9;
    pdata[3] = 4'd12;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(4'b1111, 1'b1);
      checkOutput(4'b0001 << (k % 4));
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput(4'b0000);
    checkOutput(4'b0000);

    // Fill to full with downstream stalled, then release and drain in order
    for (int k = 0; k < 4; k++) begin
      pdata[0] = 4'(k + 1);
      applyStimulus(4'b0001, 1'b0);
      checkOutput(4'b0001);
    end
    applyStimulus(4'b0001, 1'b0);
    checkOutput(4'b0000);
    checkOutput(4'b0000);
    applyStimulus(4'b0001, 1'b1);
    checkOutput(4'b0000);
    pdata[0] = 4'd9;
    applyStimulus(4'b0001, 1'b1);
    checkOutput(4'b0001);
    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) checkOutput(4'b0000);

    // Simultaneous push and pop at fill 2, wrapping pointers over ten words
    for (int k = 0; k < 2; k++) begin
      pdata[0] = 4'(k + 13);
      applyStimulus(4'b0001, 1'b0);
      checkOutput(4'b0001);
    end
    for (int k = 0; k < 10; k++) begin
      pdata[0] = 4'(k);
      applyStimulus(4'b0001, 1'b1);
      checkOutput(4'b0001);
    end
    applyStimulus(4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) checkOutput(4'b0000);

    // Build fill = 3 with five corrected words, then reset mid-cycle
    pdata[0] = 4'd7;
    pflip[0] = 7'b0000100;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(4'b0001, 1'b1);
      checkOutput(4'b0001);
    end
    applyStimulus(4'b0000, 1'b1);
    checkOutput(4'b0000);
    for (int k = 0; k < 3; k++) begin
      pdata[0] = 4'(k + 4);
      applyStimulus(4'b0001, 1'b0);
      checkOutput(4'b0001);
    end
    check("pre_rst.fill",  32'(fill),      32'd3);
    check("pre_rst.err",   32'(err_cnt),   32'd5);
    check("pre_rst.err_s", 32'(err_cnt_s), 32'd3);
    pflip[0] = 7'd0;
    applyStimulus(4'b1111, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkReset("async_rst");
    resetModel();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1'b1);
    checkOutput(4'b0001);
    applyStimulus(4'b0000, 1'b1);
    checkOutput(4'b0000);
    checkOutput(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
